// File: rtl/mem_access_unit.sv
// MEM-stage load/store initiator. Turns byte/halfword/word requests into word-wide memory
// transactions: sub-word loads are extracted and extended combinationally, sub-word stores
// run a two-cycle read-modify-write that stalls the pipeline for one cycle.
// Optional feature: define MEM_ALIGN_CHECK_EN to flag misaligned and reserved-size accesses
// on AddrErrM; otherwise AddrErrM is tied low and size 11 behaves as a word access.
module mem_access_unit (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemReadM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic        UnsignedM,
    input  logic [31:0] ALUOutM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataM,
    output logic        StallM,
    output logic        AddrErrM,
    output logic [31:0] MemA,
    output logic [31:0] MemWD,
    output logic        MemWE,
    input  logic [31:0] MemRD
);

    typedef enum logic [0:0] {StIdle, StRmwWr} state_e;

    state_e      state_q, state_d;
    logic [31:0] merge_q, merge_d;
    logic [29:0] addr_q;      // word address of the pending read-modify-write
    logic        start_rmw;
    logic        addr_err;
    logic [31:0] load_ext;

    // Alignment / reserved-size detection, only meaningful for a live request in IDLE.
`ifdef MEM_ALIGN_CHECK_EN
    logic misalign;
    always_comb begin
        misalign = ((SizeM == 2'b01) && ALUOutM[0])
                || ((SizeM == 2'b10) && (ALUOutM[1:0] != 2'b00))
                || (SizeM == 2'b11);
        addr_err = (MemReadM || MemWriteM) && misalign && (state_q == StIdle) && !RST;
    end
`else
    always_comb begin
        addr_err = 1'b0;
    end
`endif

    assign AddrErrM = addr_err;

    // Lane extraction with sign/zero extension, plus the merged word for sub-word stores.
    always_comb begin
        logic [7:0]  rd_byte;
        logic [15:0] rd_half;
        rd_byte = MemRD[{ALUOutM[1:0], 3'b000} +: 8];
        rd_half = MemRD[{ALUOutM[1], 4'b0000} +: 16];
        unique case (SizeM)
            2'b00:   load_ext = UnsignedM ? {24'h0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
            2'b01:   load_ext = UnsignedM ? {16'h0, rd_half} : {{16{rd_half[15]}}, rd_half};
            default: load_ext = MemRD;
        endcase

        merge_d = MemRD;
        if (SizeM == 2'b00) begin
            merge_d[{ALUOutM[1:0], 3'b000} +: 8] = WriteDataM[7:0];
        end else begin
            merge_d[{ALUOutM[1], 4'b0000} +: 16] = WriteDataM[15:0];
        end
    end

    // Output decode and next-state selection.
    always_comb begin
        ReadDataM = 32'h0;
        StallM    = 1'b0;
        MemWE     = 1'b0;
        MemWD     = 32'h0;
        MemA      = {ALUOutM[31:2], 2'b00};
        state_d   = state_q;
        start_rmw = 1'b0;
        if (state_q == StRmwWr) begin
            // Second half of the RMW; a reset this cycle cancels the write.
            MemA    = {addr_q, 2'b00};
            MemWD   = merge_q;
            MemWE   = !RST;
            state_d = StIdle;
        end else if (!RST && !addr_err) begin
            if (MemWriteM) begin
                if (SizeM[1]) begin
                    MemWD = WriteDataM;
                    MemWE = 1'b1;
                end else begin
                    StallM    = 1'b1;
                    state_d   = StRmwWr;
                    start_rmw = 1'b1;
                end
            end else if (MemReadM) begin
                ReadDataM = load_ext;
            end
        end
    end

    // State, merge buffer and latched address.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            merge_q <= 32'h0;
            addr_q  <= 30'h0;
        end else begin
            state_q <= state_d;
            if (start_rmw) begin
                merge_q <= merge_d;
                addr_q  <= ALUOutM[31:2];
            end
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a word memory attached to the Memory port, a
// behavioural model of expected outputs and memory contents, directed test-plan cases with
// literal expectations, then randomized traffic. Honours MEM_ALIGN_CHECK_EN when defined.
module tb_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemReadM, MemWriteM, UnsignedM;
    logic [1:0]  SizeM;
    logic [31:0] ALUOutM, WriteDataM;
    logic [31:0] ReadDataM, MemA, MemWD, MemRD;
    logic        StallM, AddrErrM, MemWE;

    // Attached memory, preloadable through a side port.
    logic [31:0] env_mem [0:1023];
    logic        pre_we;
    logic [9:0]  pre_idx;
    logic [31:0] pre_data;

    // Reference model state.
    logic [31:0] ref_mem [0:1023];
    logic        pend;
    logic [31:0] pend_addr, pend_word;
    logic [31:0] e_a, e_wd, e_rd;
    logic        e_we, e_stall, e_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 CLK = ~CLK;

    mem_access_unit dut (
        .CLK        (CLK),
        .RST        (RST),
        .MemReadM   (MemReadM),
        .MemWriteM  (MemWriteM),
        .SizeM      (SizeM),
        .UnsignedM  (UnsignedM),
        .ALUOutM    (ALUOutM),
        .WriteDataM (WriteDataM),
        .ReadDataM  (ReadDataM),
        .StallM     (StallM),
        .AddrErrM   (AddrErrM),
        .MemA       (MemA),
        .MemWD      (MemWD),
        .MemWE      (MemWE),
        .MemRD      (MemRD)
    );

    assign MemRD = env_mem[MemA[11:2]];

    always @(posedge CLK) begin
        if (pre_we) env_mem[pre_idx] <= pre_data;
        else if (MemWE) env_mem[MemA[11:2]] <= MemWD;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [31:0] load_val(input logic [31:0] w, input logic [31:0] addr,
                                             input logic [1:0] size, input logic uns);
        logic [31:0] v;
        if (size == 2'b00) begin
            v = (w >> (8 * addr[1:0])) & 32'hFF;
            if (!uns && v >= 32'h80) v = v | 32'hFFFFFF00;
        end else if (size == 2'b01) begin
            v = (w >> (16 * addr[1])) & 32'hFFFF;
            if (!uns && v >= 32'h8000) v = v | 32'hFFFF0000;
        end else begin
            v = w;
        end
        return v;
    endfunction

    function automatic logic [31:0] merge_val(input logic [31:0] w, input logic [31:0] addr,
                                              input logic [1:0] size, input logic [31:0] d);
        logic [31:0] mask;
        int          sh;
        if (size == 2'b00) begin
            sh   = 8 * addr[1:0];
            mask = 32'hFF << sh;
        end else begin
            sh   = 16 * addr[1];
            mask = 32'hFFFF << sh;
        end
        return (w & ~mask) | ((d << sh) & mask);
    endfunction

    function automatic logic is_err(input logic [31:0] addr, input logic [1:0] size);
`ifdef MEM_ALIGN_CHECK_EN
        return (size == 2'b11) || (size == 2'b01 && addr[0]) ||
               (size == 2'b10 && addr[1:0] != 2'b00);
`else
        return 1'b0;
`endif
    endfunction

    // Compute expectations from the model and compare every observable output.
    task automatic sample();
        @(negedge CLK);
        e_a     = pend ? {pend_addr[31:2], 2'b00} : {ALUOutM[31:2], 2'b00};
        e_we    = 1'b0;
        e_wd    = 32'h0;
        e_rd    = 32'h0;
        e_stall = 1'b0;
        e_err   = 1'b0;
        if (RST) begin
            // reset overrides everything
        end else if (pend) begin
            e_we = 1'b1;
            e_wd = pend_word;
        end else if ((MemReadM || MemWriteM) && is_err(ALUOutM, SizeM)) begin
            e_err = 1'b1;
        end else if (MemWriteM) begin
            if (SizeM[1]) begin
                e_we = 1'b1;
                e_wd = WriteDataM;
            end else begin
                e_stall = 1'b1;
            end
        end else if (MemReadM) begin
            e_rd = load_val(ref_mem[ALUOutM[11:2]], ALUOutM, SizeM, UnsignedM);
        end
        check("MemA", MemA, e_a);
        check("StallM", {31'h0, StallM}, {31'h0, e_stall});
        check("MemWE", {31'h0, MemWE}, {31'h0, e_we});
        check("AddrErrM", {31'h0, AddrErrM}, {31'h0, e_err});
        check("ReadDataM", ReadDataM, e_rd);
        if (e_we) check("MemWD", MemWD, e_wd);
    endtask

    // Clock edge: advance the model the same way the memory system must evolve.
    task automatic advance();
        @(posedge CLK);
        if (RST) begin
            pend = 1'b0;
        end else if (pend) begin
            ref_mem[pend_addr[11:2]] = pend_word;
            pend = 1'b0;
        end else if (e_we) begin
            ref_mem[ALUOutM[11:2]] = WriteDataM;
        end else if (e_stall) begin
            pend      = 1'b1;
            pend_addr = ALUOutM;
            pend_word = merge_val(ref_mem[ALUOutM[11:2]], ALUOutM, SizeM, WriteDataM);
        end
        #1;
    endtask

    task automatic req(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] data);
        MemReadM   = rd;
        MemWriteM  = wr;
        SizeM      = sz;
        UnsignedM  = uns;
        ALUOutM    = addr;
        WriteDataM = data;
    endtask

    initial begin
        logic [31:0] v;
        pend = 1'b0;
        pend_addr = 32'h0;
        pend_word = 32'h0;
        RST = 1'b1;
        pre_we = 1'b0;
        pre_idx = 10'h0;
        pre_data = 32'h0;
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h400, 32'h0);

        // Preload words 0x400..0x43F while held in reset.
        for (int i = 0; i < 16; i++) begin
            v = (i == 0) ? 32'h01234567 : (i == 1) ? 32'h8899AABB : $urandom;
            ref_mem[10'h100 + i] = v;
            @(negedge CLK);
            pre_we   = 1'b1;
            pre_idx  = 10'h100 + 10'(i);
            pre_data = v;
        end
        @(negedge CLK);
        pre_we = 1'b0;

        // Reset state.
        sample();
        check("rst_stall", {31'h0, StallM}, 32'h0);
        check("rst_we", {31'h0, MemWE}, 32'h0);
        check("rst_err", {31'h0, AddrErrM}, 32'h0);
        check("rst_rd", ReadDataM, 32'h0);
        advance();
        RST = 1'b0;
        sample();
        advance();

        req(1'b1, 1'b0, 2'b00, 1'b0, 32'h405, 32'h0);
        sample();
        check("lb_signed", ReadDataM, 32'hFFFFFFAA);
        check("lb_nostall", {31'h0, StallM}, 32'h0);
        advance();
        req(1'b1, 1'b0, 2'b00, 1'b1, 32'h405, 32'h0);
        sample();
        check("lbu", ReadDataM, 32'h000000AA);
        advance();
        req(1'b1, 1'b0, 2'b01, 1'b0, 32'h406, 32'h0);
        sample();
        check("lh_signed", ReadDataM, 32'hFFFF8899);
        advance();

        req(1'b0, 1'b1, 2'b00, 1'b0, 32'h406, 32'h11);
        sample();
        check("sb_c0_stall", {31'h0, StallM}, 32'h1);
        check("sb_c0_we", {31'h0, MemWE}, 32'h0);
        check("sb_c0_addr", MemA, 32'h404);
        advance();
        sample();
        check("sb_c1_we", {31'h0, MemWE}, 32'h1);
        check("sb_c1_wd", MemWD, 32'h8811AABB);
        check("sb_c1_stall", {31'h0, StallM}, 32'h0);
        advance();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
        sample();
        check("lw_after_sb", ReadDataM, 32'h8811AABB);
        advance();

        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h404, 32'hDEADBEEF);
        sample();
        check("sw_we", {31'h0, MemWE}, 32'h1);
        check("sw_stall", {31'h0, StallM}, 32'h0);
        advance();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
        sample();
        check("lw_after_sw", ReadDataM, 32'hDEADBEEF);
        advance();
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h404, 32'h8899AABB);
        sample();
        advance();

        // Reset during the write half of a halfword RMW cancels the write.
        req(1'b0, 1'b1, 2'b01, 1'b0, 32'h404, 32'h1234);
        sample();
        advance();
        RST = 1'b1;
        sample();
        check("rst_rmw_we", {31'h0, MemWE}, 32'h0);
        advance();
        RST = 1'b0;
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h404, 32'h0);
        sample();
        check("rst_rmw_mem", ReadDataM, 32'h8899AABB);
        check("rst_rmw_idle", {31'h0, StallM}, 32'h0);
        advance();

        // Misaligned word store.
        req(1'b0, 1'b1, 2'b10, 1'b0, 32'h402, 32'hCAFEF00D);
        sample();
        check("mis_addr", MemA, 32'h400);
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_err", {31'h0, AddrErrM}, 32'h1);
        check("mis_we", {31'h0, MemWE}, 32'h0);
`else
        check("mis_err", {31'h0, AddrErrM}, 32'h0);
        check("mis_we", {31'h0, MemWE}, 32'h1);
`endif
        advance();
        req(1'b1, 1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        sample();
`ifdef MEM_ALIGN_CHECK_EN
        check("mis_mem", ReadDataM, 32'h01234567);
`else
        check("mis_mem", ReadDataM, 32'hCAFEF00D);
`endif
        advance();

        // Randomized traffic; inputs held stable while a stall is expected.
        for (int c = 0; c < 400; c++) begin
            if (!e_stall) begin
                req(1'(($urandom_range(0, 3)) != 0), 1'($urandom), 2'($urandom), 1'($urandom),
                    32'h400 + $urandom_range(0, 63), $urandom);
            end
            RST = ($urandom_range(0, 49) == 0);
            sample();
            advance();
        end
        RST = 1'b0;
        req(1'b0, 1'b0, 2'b00, 1'b0, 32'h400, 32'h0);
        sample();
        advance();
        sample();
        advance();

        for (int i = 0; i < 16; i++) begin
            check("mem_final", env_mem[10'h100 + i], ref_mem[10'h100 + i]);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
